// File: rtl/fpaddsub_norm_shift_pipe.sv
// Post-add normalizer: leading-zero count, coarse (x4) then fine left shift, exponent adjust.
// Optional NORM_DENORM_CLAMP_EN limits the shift to in_exp-1 so underflowing results stay denormal.
module fpaddsub_norm_shift_pipe #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [4:0]        out_shift,
  output logic              out_zero,
  output logic              out_uflow
);

  logic              advance;
  logic [4:0]        lzc_c;
  logic [4:0]        shift_c;
  logic              zero_c;
  logic              s3_uflow_c;

  logic              s1_valid_d, s1_valid_q;
  logic [MANT_W-1:0] s1_mant_d, s1_mant_q;
  logic [EXP_W-1:0]  s1_exp_d, s1_exp_q;
  logic [4:0]        s1_lzc_d, s1_lzc_q;
  logic [4:0]        s1_shift_d, s1_shift_q;
  logic              s1_zero_d, s1_zero_q;

  logic              s2_valid_d, s2_valid_q;
  logic [MANT_W-1:0] s2_mant_d, s2_mant_q;
  logic [EXP_W-1:0]  s2_exp_d, s2_exp_q;
  logic [4:0]        s2_lzc_d, s2_lzc_q;
  logic [4:0]        s2_shift_d, s2_shift_q;
  logic              s2_zero_d, s2_zero_q;

  logic              out_valid_d, out_valid_q;
  logic [MANT_W-1:0] out_mant_d, out_mant_q;
  logic [EXP_W-1:0]  out_exp_d, out_exp_q;
  logic [4:0]        out_shift_d, out_shift_q;
  logic              out_zero_d, out_zero_q;
  logic              out_uflow_d, out_uflow_q;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // Ascending scan: the last hit is the most significant set bit.
  always_comb begin
    lzc_c  = 5'd0;
    zero_c = (in_mant == '0);
    for (int i = 0; i < MANT_W; i++) begin
      if (in_mant[i]) lzc_c = 5'(MANT_W - 1 - i);
    end
    shift_c = lzc_c;
`ifdef NORM_DENORM_CLAMP_EN
    if (!zero_c && (in_exp <= EXP_W'(lzc_c))) begin
      shift_c = (in_exp == '0) ? 5'd0 : (in_exp[4:0] - 5'd1);
    end
`else
`endif
  end

  assign s3_uflow_c = !s2_zero_q && (s2_exp_q <= EXP_W'(s2_lzc_q));

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_mant_d   = s1_mant_q;
    s1_exp_d    = s1_exp_q;
    s1_lzc_d    = s1_lzc_q;
    s1_shift_d  = s1_shift_q;
    s1_zero_d   = s1_zero_q;
    s2_valid_d  = s2_valid_q;
    s2_mant_d   = s2_mant_q;
    s2_exp_d    = s2_exp_q;
    s2_lzc_d    = s2_lzc_q;
    s2_shift_d  = s2_shift_q;
    s2_zero_d   = s2_zero_q;
    out_valid_d = out_valid_q;
    out_mant_d  = out_mant_q;
    out_exp_d   = out_exp_q;
    out_shift_d = out_shift_q;
    out_zero_d  = out_zero_q;
    out_uflow_d = out_uflow_q;
    if (advance) begin
      s1_valid_d  = in_valid;
      s1_mant_d   = in_mant;
      s1_exp_d    = in_exp;
      s1_lzc_d    = lzc_c;
      s1_shift_d  = shift_c;
      s1_zero_d   = zero_c;

      s2_valid_d  = s1_valid_q;
      s2_mant_d   = s1_mant_q << {s1_shift_q[4:2], 2'b00};
      s2_exp_d    = s1_exp_q;
      s2_lzc_d    = s1_lzc_q;
      s2_shift_d  = s1_shift_q;
      s2_zero_d   = s1_zero_q;

      out_valid_d = s2_valid_q;
      out_zero_d  = s2_zero_q;
      out_uflow_d = s3_uflow_c;
      out_mant_d  = s2_zero_q ? '0 : (s2_mant_q << s2_shift_q[1:0]);
      out_shift_d = s2_zero_q ? 5'd0 : s2_shift_q;
      // Compare-before-subtract keeps the unsigned exponent from wrapping.
      out_exp_d   = (s2_zero_q || s3_uflow_c) ? '0 : (s2_exp_q - EXP_W'(s2_lzc_q));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mant_q   <= '0;
      s1_exp_q    <= '0;
      s1_lzc_q    <= '0;
      s1_shift_q  <= '0;
      s1_zero_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_mant_q   <= '0;
      s2_exp_q    <= '0;
      s2_lzc_q    <= '0;
      s2_shift_q  <= '0;
      s2_zero_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_shift_q <= '0;
      out_zero_q  <= 1'b0;
      out_uflow_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mant_q   <= s1_mant_d;
      s1_exp_q    <= s1_exp_d;
      s1_lzc_q    <= s1_lzc_d;
      s1_shift_q  <= s1_shift_d;
      s1_zero_q   <= s1_zero_d;
      s2_valid_q  <= s2_valid_d;
      s2_mant_q   <= s2_mant_d;
      s2_exp_q    <= s2_exp_d;
      s2_lzc_q    <= s2_lzc_d;
      s2_shift_q  <= s2_shift_d;
      s2_zero_q   <= s2_zero_d;
      out_valid_q <= out_valid_d;
      out_mant_q  <= out_mant_d;
      out_exp_q   <= out_exp_d;
      out_shift_q <= out_shift_d;
      out_zero_q  <= out_zero_d;
      out_uflow_q <= out_uflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_mant  = out_mant_q;
  assign out_exp   = out_exp_q;
  assign out_shift = out_shift_q;
  assign out_zero  = out_zero_q;
  assign out_uflow = out_uflow_q;

endmodule

// File: tb/tb_fpaddsub_norm_shift_pipe.sv
// Randomized bench for fpaddsub_norm_shift_pipe with an arithmetic reference model and scoreboard.
module tb_fpaddsub_norm_shift_pipe;

  typedef struct packed {
    logic [31:0] mant;
    logic [7:0]  exp;
    logic [4:0]  shift;
    logic        zero;
    logic        uflow;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_mant = '0;
  logic [7:0]  in_exp = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_mant;
  logic [7:0]  out_exp;
  logic [4:0]  out_shift;
  logic        out_zero;
  logic        out_uflow;

  int   n_checks = 0;
  int   n_pass = 0;
  res_t exp_q[$];
  logic prev_stall = 1'b0;
  res_t held;
  logic rand_done;

  fpaddsub_norm_shift_pipe #(.EXP_W(8), .MANT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mant(in_mant), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant), .out_exp(out_exp),
    .out_shift(out_shift), .out_zero(out_zero), .out_uflow(out_uflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  // Normalize: shift left until bit 31 is set, the exponent pays for each shift.
  function automatic res_t model(input logic [31:0] m, input logic [7:0] e);
    res_t r;
    int lz, sh, ei;
    r = '0;
    if (m == 0) begin
      r.zero = 1'b1;
      return r;
    end
    lz = 0;
    while (m[31 - lz] == 1'b0) lz++;
    ei = int'(e);
    sh = lz;
`ifdef NORM_DENORM_CLAMP_EN
    if (ei <= lz) sh = (ei == 0) ? 0 : ei - 1;
`endif
    r.shift = 5'(sh);
    r.mant  = m << sh;
    if (ei > lz) r.exp = 8'(ei - lz);
    else r.uflow = 1'b1;
    return r;
  endfunction

  // Compare process: every negedge, outputs against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (prev_stall) chk("stall_stable", {out_valid, out_mant, out_exp, out_shift, out_zero, out_uflow},
                          {1'b1, held});
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out_valid", out_valid, 1'b0);
        else begin
          chk("out_mant", out_mant, exp_q[0].mant);
          chk("out_exp", out_exp, exp_q[0].exp);
          chk("out_shift", out_shift, exp_q[0].shift);
          chk("out_zero", out_zero, exp_q[0].zero);
          chk("out_uflow", out_uflow, exp_q[0].uflow);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      held = {out_mant, out_exp, out_shift, out_zero, out_uflow};
      if (in_valid && in_ready) exp_q.push_back(model(in_mant, in_exp));
    end
  end

  // Entered and left at posedge+1; the beat transfers on the edge just before returning.
  task automatic send(input logic [31:0] m, input logic [7:0] e);
    bit got = 0;
    in_valid = 1'b1;
    in_mant  = m;
    in_exp   = e;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("send_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    res_t r;
    r = model(32'h8000_0000, 8'd100);
    chk("model_norm", r, {32'h8000_0000, 8'd100, 5'd0, 1'b0, 1'b0});
    r = model(32'h0001_2345, 8'd120);
    chk("model_lz15", r, {32'h91A2_8000, 8'd105, 5'd15, 1'b0, 1'b0});
    r = model(32'h0, 8'd77);
    chk("model_zero", r, {32'h0, 8'd0, 5'd0, 1'b1, 1'b0});
    r = model(32'h0000_0001, 8'd10);
`ifdef NORM_DENORM_CLAMP_EN
    chk("model_uflow", r, {32'h0000_0200, 8'd0, 5'd9, 1'b0, 1'b1});
`else
    chk("model_uflow", r, {32'h8000_0000, 8'd0, 5'd31, 1'b0, 1'b1});
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_state", {out_valid, out_mant, out_exp, out_shift, out_zero, out_uflow, in_ready},
        {1'b0, 32'h0, 8'h0, 5'h0, 1'b0, 1'b0, 1'b1});
    @(posedge clk); #1;

    send(32'h8000_0000, 8'd100);
    @(negedge clk); chk("lat_c1", out_valid, 1'b0);
    @(negedge clk); chk("lat_c2", out_valid, 1'b0);
    @(negedge clk); chk("lat_c3", out_valid, 1'b1);
    @(posedge clk); #1;

    send(32'h0001_2345, 8'd120);
    send(32'h0, 8'd50);
    send(32'h0000_0001, 8'd10);
    send(32'h0000_0001, 8'd0);
    send(32'h0000_0010, 8'd27);
    send(32'h0000_0010, 8'd28);
    drain();

    fork
      for (int i = 0; i < 5; i++) send(32'h0000_1000 << i, 8'd60 + 8'(i));
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 3; i++) send(32'h00F0_0000 >> i, 8'd90);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_flush_valid", out_valid, 1'b0);
    repeat (6) @(posedge clk);
    #1;

    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [31:0] m;
          logic [7:0]  e;
          m = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
          e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 33)) : 8'($urandom);
          send(m, e);
          repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0) begin
            @(posedge clk); #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
